// File: rtl/jam_cost_eval.sv
// jam_cost_eval: sums 8 ROM costs per candidate permutation and tracks the minimum total and its match count
module jam_cost_eval #(
  parameter int COST_W = 7,
  parameter int SUM_W  = 10,
  parameter int CNT_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              perm_valid,
  output logic              perm_ready,
  input  logic [23:0]       perm,
  input  logic              perm_last,
  output logic [2:0]        W,
  output logic [2:0]        J,
  input  logic [COST_W-1:0] Cost,
  output logic [SUM_W-1:0]  MinCost,
  output logic [CNT_W-1:0]  MatchCount,
  output logic              Valid
);
  typedef enum logic [1:0] {IDLE, EVAL, CMP, DONE} state_t;
  state_t            r_state, w_next;
  logic [2:0]        r_idx;
  logic [SUM_W-1:0]  r_acc, r_min;
  logic [CNT_W-1:0]  r_cnt;
  logic [23:0]       r_perm;
  logic              r_last;
  logic              w_accept;
  always_ff @(posedge CLK)
    if (RST) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_accept   = perm_valid && r_state == IDLE;
    perm_ready = r_state == IDLE;
    Valid      = r_state == DONE;
    W          = r_state == EVAL ? r_idx : 3'd0;
    J          = r_state == EVAL ? r_perm[r_idx*3 +: 3] : 3'd0;
    w_next     = r_state == IDLE ? (w_accept ? EVAL : IDLE) :
                 r_state == EVAL ? (r_idx == 3'd7 ? CMP : EVAL) :
                 r_state == CMP  ? (r_last ? DONE : IDLE) : DONE;
  end
  always_ff @(posedge CLK)
    if (RST) begin
      r_idx  <= '0;
      r_acc  <= '0;
      r_perm <= '0;
      r_last <= 1'b0;
      r_min  <= '1;
      r_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_perm <= perm;
        r_last <= perm_last;
        r_idx  <= '0;
        r_acc  <= '0;
      end
      if (r_state == EVAL) begin
        r_acc <= r_acc + SUM_W'(Cost);
        r_idx <= r_idx + 3'd1;
      end
      if (r_state == CMP) begin
        if (r_acc < r_min) begin
          r_min <= r_acc;
          r_cnt <= CNT_W'(1);
        end else if (r_acc == r_min && r_cnt != '1)
          r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  assign MinCost    = r_min;
  assign MatchCount = r_cnt;
endmodule

// File: tb/tb_jam_cost_eval.sv
// tb_jam_cost_eval: randomized and directed scenarios against a table-driven minimum/count model
module tb_jam_cost_eval;
  logic        CLK = 0, RST = 1, perm_valid = 0, perm_last = 0;
  logic [23:0] perm = '0;
  logic        perm_ready, Valid;
  logic [2:0]  W, J;
  logic [6:0]  Cost;
  logic [9:0]  MinCost;
  logic [3:0]  MatchCount;
  logic [6:0]  tbl [8][8];
  int checks = 0, errors = 0;
  int m_min, m_cnt;

  jam_cost_eval dut (
    .CLK(CLK), .RST(RST), .perm_valid(perm_valid), .perm_ready(perm_ready),
    .perm(perm), .perm_last(perm_last), .W(W), .J(J), .Cost(Cost),
    .MinCost(MinCost), .MatchCount(MatchCount), .Valid(Valid)
  );

  assign Cost = tbl[W][J];
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic set_total(input int t);
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++)
        tbl[w][j] = 7'(t / 8 + (w == 0 ? t % 8 : 0));
  endtask

  task automatic do_reset();
    RST = 1;
    perm_valid = 0;
    @(posedge CLK); #1;
    RST = 0;
    m_min = 1023;
    m_cnt = 0;
  endtask

  task automatic send_perm(input logic [23:0] p, input bit last, input bit noisy);
    int s, k, wait_n;
    logic [23:0] pv;
    wait_n = 0;
    while (!perm_ready && wait_n < 20) begin
      @(posedge CLK); #1;
      wait_n++;
    end
    checks++;
    if (!perm_ready) begin
      errors++;
      $display("FAIL ready_wait: perm_ready=%0b, required 1 within 20 cycles", perm_ready);
    end
    pv = p;
    s = 0;
    for (int i = 0; i < 8; i++) s += tbl[i][pv[3*i +: 3]];
    if (s < m_min) begin
      m_min = s;
      m_cnt = 1;
    end else if (s == m_min && m_cnt < 15) m_cnt++;
    perm = p;
    perm_last = last;
    perm_valid = 1;
    @(posedge CLK); #1;
    perm_valid = 0;
    for (k = 0; k < 8; k++) begin
      if (noisy) begin
        perm_valid = 1;
        perm = 24'($urandom);
        perm_last = 1'($urandom);
      end
      checks++;
      if (W !== 3'(k) || J !== pv[3*k +: 3] || perm_ready !== 1'b0) begin
        errors++;
        $display("FAIL eval_wj[%0d]: W=%0d J=%0d ready=%0b, required W=%0d J=%0d ready=0",
                 k, W, J, perm_ready, k, pv[3*k +: 3]);
      end
      @(posedge CLK); #1;
    end
    perm_valid = 0;
    checks++;
    if (perm_ready !== 1'b0 || W !== 3'd0 || J !== 3'd0) begin
      errors++;
      $display("FAIL cmp_cycle: ready=%0b W=%0d J=%0d, required 0 0 0", perm_ready, W, J);
    end
    @(posedge CLK); #1;
    checks++;
    if (perm_ready !== !last || Valid !== last) begin
      errors++;
      $display("FAIL after_cmp: ready=%0b valid=%0b, required ready=%0b valid=%0b",
               perm_ready, Valid, !last, last);
    end
  endtask

  task automatic test_reset();
    set_total(0);
    do_reset();
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (MinCost !== 10'd1023 || MatchCount !== 4'd0 || Valid !== 1'b0 ||
          perm_ready !== 1'b1 || W !== 3'd0 || J !== 3'd0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: min=%0d cnt=%0d valid=%0b ready=%0b W=%0d J=%0d, required 1023 0 0 1 0 0",
                 c, MinCost, MatchCount, Valid, perm_ready, W, J);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_identity();
    do_reset();
    set_total(40);
    for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) tbl[w][j] = 7'd5;
    send_perm(24'hFAC688, 1, 0);
    checks++;
    if (MinCost !== 10'd40 || MatchCount !== 4'd1 || Valid !== 1'b1) begin
      errors++;
      $display("FAIL identity: min=%0d cnt=%0d valid=%0b, required 40 1 1", MinCost, MatchCount, Valid);
    end
  endtask

  task automatic test_ties();
    do_reset();
    set_total(50); send_perm(24'($urandom), 0, 0);
    set_total(40); send_perm(24'($urandom), 0, 0);
    set_total(40); send_perm(24'($urandom), 1, 0);
    checks++;
    if (MinCost !== 10'd40 || MatchCount !== 4'd2 || Valid !== 1'b1) begin
      errors++;
      $display("FAIL ties: min=%0d cnt=%0d valid=%0b, required 40 2 1", MinCost, MatchCount, Valid);
    end
  endtask

  task automatic test_smaller();
    do_reset();
    set_total(40); send_perm(24'($urandom), 0, 0);
    set_total(40); send_perm(24'($urandom), 0, 0);
    set_total(30); send_perm(24'($urandom), 1, 0);
    checks++;
    if (MinCost !== 10'd30 || MatchCount !== 4'd1) begin
      errors++;
      $display("FAIL smaller: min=%0d cnt=%0d, required 30 1", MinCost, MatchCount);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    set_total(56);
    for (int n = 1; n <= 17; n++) begin
      send_perm(24'($urandom), n == 17, 0);
      if (n == 15 || n == 16) begin
        checks++;
        if (MatchCount !== 4'd15) begin
          errors++;
          $display("FAIL sat_mid[%0d]: cnt=%0d, required 15", n, MatchCount);
        end
      end
    end
    checks++;
    if (MinCost !== 10'd56 || MatchCount !== 4'd15 || Valid !== 1'b1) begin
      errors++;
      $display("FAIL saturate: min=%0d cnt=%0d valid=%0b, required 56 15 1", MinCost, MatchCount, Valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_total(80);
    perm = 24'($urandom);
    perm_last = 1;
    perm_valid = 1;
    @(posedge CLK); #1;
    perm_valid = 0;
    repeat (3) begin @(posedge CLK); #1; end
    checks++;
    if (W !== 3'd3) begin
      errors++;
      $display("FAIL mid_eval_pos: W=%0d, required 3", W);
    end
    do_reset();
    checks++;
    if (perm_ready !== 1'b1 || MinCost !== 10'd1023 || MatchCount !== 4'd0 || W !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset: ready=%0b min=%0d cnt=%0d W=%0d, required 1 1023 0 0",
               perm_ready, MinCost, MatchCount, W);
    end
    set_total(21);
    send_perm(24'($urandom), 1, 0);
    checks++;
    if (MinCost !== 10'd21 || MatchCount !== 4'd1) begin
      errors++;
      $display("FAIL after_abort: min=%0d cnt=%0d, required 21 1", MinCost, MatchCount);
    end
  endtask

  task automatic test_noisy_valid();
    do_reset();
    for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) tbl[w][j] = 7'($urandom_range(0, 127));
    send_perm(24'($urandom), 0, 1);
    send_perm(24'($urandom), 1, 1);
    checks++;
    if (MinCost !== 10'(m_min) || MatchCount !== 4'(m_cnt)) begin
      errors++;
      $display("FAIL noisy: min=%0d cnt=%0d, required %0d %0d", MinCost, MatchCount, m_min, m_cnt);
    end
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++)
        tbl[w][j] = 7'(r < 3 ? $urandom_range(0, 2) : $urandom_range(0, 127));
      n = $urandom_range(3, 20);
      for (int p = 0; p < n; p++) begin
        send_perm(24'($urandom), p == n - 1, 0);
        checks++;
        if (MinCost !== 10'(m_min) || MatchCount !== 4'(m_cnt)) begin
          errors++;
          $display("FAIL random[%0d.%0d]: min=%0d cnt=%0d, required %0d %0d",
                   r, p, MinCost, MatchCount, m_min, m_cnt);
        end
      end
      repeat (3) begin @(posedge CLK); #1; end
      checks++;
      if (Valid !== 1'b1 || perm_ready !== 1'b0 || MinCost !== 10'(m_min)) begin
        errors++;
        $display("FAIL done_hold[%0d]: valid=%0b ready=%0b min=%0d, required 1 0 %0d",
                 r, Valid, perm_ready, MinCost, m_min);
      end
    end
  endtask

  initial begin
    m_min = 1023;
    m_cnt = 0;
    test_reset();
    test_identity();
    test_ties();
    test_smaller();
    test_saturate();
    test_reset_mid();
    test_noisy_valid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
